// File: rtl/adt7420_responder_if.sv
// Host-side signals of the ADT7420 I2C responder: temperature input plus
// configuration/status outputs. The slave modport is the responder's view.
interface adt7420_responder_if;
  logic [15:0] temp_in;
  logic [7:0]  cfg_reg;
  logic        busy;
  logic        rd_strobe;

  modport master (output temp_in, input cfg_reg, busy, rd_strobe);
  modport slave  (input temp_in, output cfg_reg, busy, rd_strobe);
endinterface

// File: rtl/adt7420_responder.sv
// ADT7420-style I2C target: pointer/config/temperature register map.
// Define ADT_RESP_ID_REG_EN to make pointer 8'h0B return DEVICE_ID.
module adt7420_responder #(
  parameter logic [6:0] I2C_ADDR  = 7'h4B,
  parameter logic [7:0] DEVICE_ID = 8'hCB
) (
  input  logic               system_clk,
  input  logic               rst,
  input  logic               SCL,
  inout  wire                SDA,
  adt7420_responder_if.slave host
);

`ifdef ADT_RESP_ID_REG_EN
  localparam bit ID_REG_EN = 1'b1;
`else
  localparam bit ID_REG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  // [1] is the synchronized value, [2] the previous synchronized value.
  logic [2:0] scl_pipe, sda_pipe;
  logic       scl_s, scl_d, sda_s, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_nxt;
  logic [3:0]  bit_cnt_q, bit_cnt_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic [7:0]  ptr_q, ptr_nxt;
  logic [15:0] shadow_q, shadow_nxt;
  logic [7:0]  cfg_q, cfg_nxt;
  logic        sda_oe_q, sda_oe_nxt;
  logic        busy_q, busy_nxt;
  logic        rw_q, rw_nxt;
  logic        ptr_phase_q, ptr_phase_nxt;
  logic        rd_strobe_q, rd_strobe_nxt;
  logic        fall_q;
  logic        load_tx;
  logic [7:0]  rx_byte;
  logic [7:0]  rd_data;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      fall_q   <= 1'b0;
    end else begin
      scl_pipe <= {scl_pipe[1:0], SCL};
      sda_pipe <= {sda_pipe[1:0], SDA};
      fall_q   <= scl_fall;
    end
  end

  assign scl_s     = scl_pipe[1];
  assign scl_d     = scl_pipe[2];
  assign sda_s     = sda_pipe[1];
  assign sda_d     = sda_pipe[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  always_comb begin
    rd_data = 8'h00;
    case (ptr_q)
      8'h00:   rd_data = shadow_q[15:8];
      8'h01:   rd_data = shadow_q[7:0];
      8'h03:   rd_data = cfg_q;
      8'h0B:   rd_data = ID_REG_EN ? DEVICE_ID : 8'h00;
      default: rd_data = 8'h00;
    endcase
  end

  // NOTE: every signal gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt     = state_q;
    bit_cnt_nxt   = bit_cnt_q;
    shift_nxt     = shift_q;
    ptr_nxt       = ptr_q;
    shadow_nxt    = shadow_q;
    cfg_nxt       = cfg_q;
    sda_oe_nxt    = sda_oe_q;
    busy_nxt      = busy_q;
    rw_nxt        = rw_q;
    ptr_phase_nxt = ptr_phase_q;
    rd_strobe_nxt = 1'b0;
    load_tx       = 1'b0;

    if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_nxt = 4'd0;
              if (rx_byte[7:1] == I2C_ADDR) begin
                state_nxt     = ADDR_ACK;
                rw_nxt        = rx_byte[0];
                ptr_phase_nxt = 1'b1;
                if (rx_byte[0]) shadow_nxt = host.temp_in;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        // bit_cnt 0: waiting to drive ACK after the 8th fall; 1: ACK clocked.
        ADDR_ACK, WR_ACK: begin
          if (scl_rise) bit_cnt_nxt = 4'd1;
          if (fall_q) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_nxt = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              load_tx = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              state_nxt   = WR_BYTE;
              bit_cnt_nxt = 4'd0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_nxt = 4'd0;
              state_nxt   = WR_ACK;
              if (ptr_phase_q) begin
                ptr_nxt       = rx_byte;
                ptr_phase_nxt = 1'b0;
              end else begin
                if (ptr_q == 8'h03) cfg_nxt = rx_byte;
                ptr_nxt = ptr_q + 8'd1;
              end
            end
          end
        end
        RD_BYTE: begin
          if (fall_q) begin
            shift_nxt  = {shift_q[6:0], 1'b0};
            sda_oe_nxt = ~shift_q[6];
          end
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_nxt = 4'd0;
              state_nxt   = RD_ACK;
              ptr_nxt     = ptr_q + 8'd1;
            end
          end
        end
        RD_ACK: begin
          if (fall_q && bit_cnt_q == 4'd0) sda_oe_nxt = 1'b0;
          if (scl_rise) begin
            if (sda_s) state_nxt = IDLE;
            else       bit_cnt_nxt = 4'd1;
          end
          if (fall_q && bit_cnt_q == 4'd1) load_tx = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase

      // The first bit goes out on the same post-fall cycle the byte is loaded.
      if (load_tx) begin
        state_nxt     = RD_BYTE;
        shift_nxt     = rd_data;
        sda_oe_nxt    = ~rd_data[7];
        bit_cnt_nxt   = 4'd0;
        rd_strobe_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      shadow_q    <= 16'h0000;
      cfg_q       <= 8'h00;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      ptr_phase_q <= 1'b0;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      shift_q     <= shift_nxt;
      ptr_q       <= ptr_nxt;
      shadow_q    <= shadow_nxt;
      cfg_q       <= cfg_nxt;
      sda_oe_q    <= sda_oe_nxt;
      busy_q      <= busy_nxt;
      rw_q        <= rw_nxt;
      ptr_phase_q <= ptr_phase_nxt;
      rd_strobe_q <= rd_strobe_nxt;
    end
  end

  assign SDA            = sda_oe_q ? 1'b0 : 1'bz;
  assign host.cfg_reg   = cfg_q;
  assign host.busy      = busy_q;
  assign host.rd_strobe = rd_strobe_q;

endmodule

// File: tb/tb_adt7420_responder.sv
// Bench for adt7420_responder: bit-banged I2C initiator, table vectors,
// hand-written corner sequences and randomized transactions against a model.
module tb_adt7420_responder;
  localparam int T = 8;  // system clocks per SCL phase step

`ifdef ADT_RESP_ID_REG_EN
  localparam logic [7:0] ID_EXP = 8'hCB;
`else
  localparam logic [7:0] ID_EXP = 8'h00;
`endif

  typedef logic [7:0] bytes_t [4];
  typedef struct {
    logic        wr_en;
    logic [7:0]  ptr;
    logic [7:0]  wdata;
    logic [15:0] temp;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_cfg;
  } vec_t;

  logic system_clk = 1'b0;
  logic rst;
  logic scl;
  logic sda_drive_low;
  wire  SDA;

  pullup (SDA);
  assign SDA = sda_drive_low ? 1'b0 : 1'bz;

  adt7420_responder_if host ();

  adt7420_responder #(.I2C_ADDR(7'h4B), .DEVICE_ID(8'hCB)) dut (
    .system_clk(system_clk),
    .rst       (rst),
    .SCL       (scl),
    .SDA       (SDA),
    .host      (host)
  );

  always #5 system_clk = ~system_clk;

  int vectors = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  logic mid_busy;
  logic sda_after_ack;

  // Reference model state
  logic [7:0]  m_ptr, m_cfg;
  logic [15:0] m_shadow;

  always @(posedge system_clk) if (host.rd_strobe) strobe_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge system_clk);
  endtask

  task automatic bus_start();
    sda_drive_low = 1'b0; wait_clk(T);
    scl = 1'b1;           wait_clk(T);
    sda_drive_low = 1'b1; wait_clk(T);
    scl = 1'b0;           wait_clk(T);
  endtask

  task automatic bus_stop();
    sda_drive_low = 1'b1; wait_clk(T);
    scl = 1'b1;           wait_clk(T);
    sda_drive_low = 1'b0; wait_clk(T);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sda_drive_low = ~b[i]; wait_clk(T);
      scl = 1'b1;            wait_clk(T);
      scl = 1'b0;            wait_clk(T);
    end
    sda_drive_low = 1'b0; wait_clk(T);
    scl = 1'b1;           wait_clk(T / 2);
    acked = (SDA === 1'b0);
    wait_clk(T / 2);
    scl = 1'b0;           wait_clk(T);
    sda_after_ack = SDA;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    b = 8'h00;
    sda_drive_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(T);
      scl = 1'b1; wait_clk(T / 2);
      b[i] = SDA;
      wait_clk(T / 2);
      scl = 1'b0;
    end
    wait_clk(T);
    sda_drive_low = ack; wait_clk(T);
    scl = 1'b1;          wait_clk(T);
    scl = 1'b0;          wait_clk(2);
    sda_drive_low = 1'b0; wait_clk(T);
  endtask

  task automatic wr_txn(input logic [7:0] addr_byte, input bytes_t d, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    mid_busy = host.busy;
    send_byte(addr_byte, a);
    if (a) acks++;
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], a);
      if (a) acks++;
    end
    bus_stop();
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] ptr, input int n,
                        output bytes_t got, output int acks);
    logic a;
    logic [7:0] b;
    acks = 0;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    bus_start();
    mid_busy = host.busy;
    if (set_ptr) begin
      send_byte(8'h96, a); if (a) acks++;
      send_byte(ptr, a);   if (a) acks++;
      bus_start();
    end
    send_byte(8'h97, a); if (a) acks++;
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, b);
      got[i] = b;
    end
    bus_stop();
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] p);
    case (p)
      8'h00:   return m_shadow[15:8];
      8'h01:   return m_shadow[7:0];
      8'h03:   return m_cfg;
      8'h0B:   return ID_EXP;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_wr(input string tag, input logic [7:0] addr_byte, input bytes_t d, input int n);
    int acks;
    logic ok;
    wr_txn(addr_byte, d, n, acks);
    ok = (addr_byte[7:1] == 7'h4B) && !addr_byte[0];
    if (ok && n > 0) begin
      m_ptr = d[0];
      for (int i = 1; i < n; i++) begin
        if (m_ptr == 8'h03) m_cfg = d[i];
        m_ptr = m_ptr + 8'd1;
      end
    end
    check({tag, " acks"}, 16'(acks), ok ? 16'(n + 1) : 16'd0);
    check({tag, " cfg"}, {8'h00, host.cfg_reg}, {8'h00, m_cfg});
    check({tag, " busy after stop"}, {15'd0, host.busy}, 16'd0);
  endtask

  task automatic model_rd(input string tag, input logic set_ptr, input logic [7:0] ptr,
                          input int n, input logic [15:0] temp);
    bytes_t got;
    int acks;
    host.temp_in = temp;
    rd_txn(set_ptr, ptr, n, got, acks);
    if (set_ptr) m_ptr = ptr;
    m_shadow = temp;
    check({tag, " acks"}, 16'(acks), set_ptr ? 16'd3 : 16'd1);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d ptr%02h", tag, i, m_ptr), {8'h00, got[i]}, {8'h00, m_read(m_ptr)});
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  initial begin
    vec_t   vecs [9];
    bytes_t wd, got;
    int     acks, s0;
    logic   a;
    logic [7:0] b0, b1;
    logic [6:0] bad;

    vecs[0] = '{1'b1, 8'h03, 8'hA5, 16'h0C80, 8'hA5, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 16'h0C80, 8'h0C, 8'hA5};
    vecs[2] = '{1'b0, 8'h01, 8'h00, 16'h0C80, 8'h80, 8'hA5};
    vecs[3] = '{1'b0, 8'h02, 8'h00, 16'h0C80, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 8'h02, 8'h55, 16'h0C80, 8'h00, 8'hA5};
    vecs[5] = '{1'b1, 8'h0B, 8'h77, 16'h0C80, ID_EXP, 8'hA5};
    vecs[6] = '{1'b1, 8'h40, 8'h12, 16'h0C80, 8'h00, 8'hA5};
    vecs[7] = '{1'b1, 8'h03, 8'h3C, 16'h0C80, 8'h3C, 8'h3C};
    vecs[8] = '{1'b0, 8'h01, 8'h00, 16'h1234, 8'h34, 8'h3C};

    for (int i = 0; i < 4; i++) wd[i] = 8'h00;
    rst = 1'b0; scl = 1'b1; sda_drive_low = 1'b0; host.temp_in = 16'h0000;
    #2 rst = 1'b1;
    wait_clk(4);
    check("reset SDA released", {15'd0, SDA}, 16'd1);
    check("reset busy", {15'd0, host.busy}, 16'd0);
    check("reset rd_strobe", {15'd0, host.rd_strobe}, 16'd0);
    check("reset cfg_reg", {8'h00, host.cfg_reg}, 16'h0000);
    rst = 1'b0;
    wait_clk(5);

    // Table-driven register accesses
    for (int i = 0; i < 9; i++) begin
      host.temp_in = vecs[i].temp;
      if (vecs[i].wr_en) begin
        wd[0] = vecs[i].ptr; wd[1] = vecs[i].wdata;
        wr_txn(8'h96, wd, 2, acks);
        check($sformatf("vec%0d write acks", i), 16'(acks), 16'd3);
        check($sformatf("vec%0d ACK released after one period", i), {15'd0, sda_after_ack}, 16'd1);
      end
      rd_txn(1'b1, vecs[i].ptr, 1, got, acks);
      check($sformatf("vec%0d read acks", i), 16'(acks), 16'd3);
      check($sformatf("vec%0d read data", i), {8'h00, got[0]}, {8'h00, vecs[i].exp_rd});
      check($sformatf("vec%0d cfg_reg", i), {8'h00, host.cfg_reg}, {8'h00, vecs[i].exp_cfg});
    end

    // Pointer write, Sr, two-byte read
    host.temp_in = 16'h0C80;
    s0 = strobe_cnt;
    rd_txn(1'b1, 8'h00, 2, got, acks);
    check("temp read acks", 16'(acks), 16'd3);
    check("temp read busy mid", {15'd0, mid_busy}, 16'd1);
    check("temp read msb", {8'h00, got[0]}, 16'h000C);
    check("temp read lsb", {8'h00, got[1]}, 16'h0080);
    check("temp read busy after stop", {15'd0, host.busy}, 16'd0);
    check("temp read rd_strobe pulses", 16'(strobe_cnt - s0), 16'd2);

    // Wrong address: no ACK, no write
    wd[0] = 8'h03; wd[1] = 8'h77;
    wr_txn(8'h94, wd, 2, acks);
    check("bad addr acks", 16'(acks), 16'd0);
    check("bad addr cfg unchanged", {8'h00, host.cfg_reg}, 16'h003C);
    check("bad addr busy after stop", {15'd0, host.busy}, 16'd0);

    // Shadow coherence across a temp_in change mid-read
    host.temp_in = 16'h0C80;
    bus_start();
    send_byte(8'h96, a); send_byte(8'h00, a); bus_start(); send_byte(8'h97, a);
    recv_byte(1'b1, b0);
    host.temp_in = 16'h1900;
    recv_byte(1'b0, b1);
    bus_stop();
    check("coherent msb", {8'h00, b0}, 16'h000C);
    check("coherent lsb", {8'h00, b1}, 16'h0080);

    // Pointer wrap FF -> 00 -> 01, then current-address read
    host.temp_in = 16'h0C80;
    wd[0] = 8'hFF; wd[1] = 8'h11; wd[2] = 8'h22;
    wr_txn(8'h96, wd, 3, acks);
    check("wrap write acks", 16'(acks), 16'd4);
    rd_txn(1'b0, 8'h00, 1, got, acks);
    check("wrap read acks", 16'(acks), 16'd1);
    check("wrap read data", {8'h00, got[0]}, 16'h0080);
    check("wrap cfg unchanged", {8'h00, host.cfg_reg}, 16'h003C);

    // Reset during the 4th data bit of a cfg read (A5: 4th bit is 0)
    wd[0] = 8'h03; wd[1] = 8'hA5;
    wr_txn(8'h96, wd, 2, acks);
    bus_start();
    send_byte(8'h96, a); send_byte(8'h03, a); bus_start(); send_byte(8'h97, a);
    sda_drive_low = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_clk(T); scl = 1'b1; wait_clk(T); scl = 1'b0;
    end
    wait_clk(T);
    check("pre-reset SDA driven low", {15'd0, SDA}, 16'd0);
    rst = 1'b1;
    #1;
    check("reset releases SDA", {15'd0, SDA}, 16'd1);
    wait_clk(1);
    check("mid reset cfg cleared", {8'h00, host.cfg_reg}, 16'h0000);
    check("mid reset busy", {15'd0, host.busy}, 16'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(T);
    bus_stop();
    m_ptr = 8'h00; m_cfg = 8'h00; m_shadow = 16'h0000;
    wd[0] = 8'h03; wd[1] = 8'h5A;
    model_wr("post reset write", 8'h96, wd, 2);
    model_rd("post reset read", 1'b1, 8'h03, 1, 16'h0C80);

    // Randomized transactions against the model
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          case ($urandom_range(0, 5))
            0: wd[0] = 8'h03;
            1: wd[0] = 8'hFE;
            2: wd[0] = 8'h0B;
            3: wd[0] = 8'($urandom_range(0, 3));
            default: wd[0] = 8'($urandom);
          endcase
          wd[1] = 8'($urandom); wd[2] = 8'($urandom);
          model_wr($sformatf("rand%0d write", t), 8'h96, wd, $urandom_range(0, 3));
        end
        2: begin
          model_rd($sformatf("rand%0d read", t), 1'($urandom), 8'($urandom_range(0, 4)) | (($urandom_range(0, 3) == 0) ? 8'hF8 : 8'h00),
                   $urandom_range(1, 3), 16'($urandom));
        end
        default: begin
          bad = 7'($urandom);
          if (bad == 7'h4B) bad = 7'h4A;
          wd[0] = 8'($urandom);
          model_wr($sformatf("rand%0d bad addr", t), {bad, 1'($urandom)}, wd, 1);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/adt7420_responder.md
ADT7420_RESPONDER -- requirements
Module: adt7420_responder

Interface
REQ-001 The block SHALL have parameter I2C_ADDR, default 7'h4B, the 7-bit target address it responds to.
REQ-002 The block SHALL have parameter DEVICE_ID, default 8'hCB, the value returned by the ID register at pointer 8'h0B.
REQ-003 The block SHALL have port system_clk, input, 1 bit, the single clock (100 MHz).
REQ-004 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port SCL, input, 1 bit, the I2C clock from the initiator.
REQ-006 The block SHALL have port SDA, inout, 1 bit, open-drain I2C data, driven only to 0 or z.
REQ-007 The block SHALL have port temp_in, input, 16 bits, the temperature word in ADT7420 format (13-bit value in [15:3]).
REQ-008 The block SHALL have port cfg_reg, output, 8 bits, the configuration register last written at pointer 8'h03.
REQ-009 The block SHALL have port busy, output, 1 bit, high between a detected START and the following STOP.
REQ-010 The block SHALL have port rd_strobe, output, 1 bit, a one-cycle pulse each time a data byte is loaded for transmission.

Function
REQ-011 SCL and SDA SHALL be passed through 2-flop synchronizers, and all edge detection SHALL use the synchronized values.
REQ-012 START (SDA falling while SCL high) SHALL force state ADDR from any state, including a repeated START mid-transfer.
REQ-013 STOP (SDA rising while SCL high) SHALL force state IDLE from any state and release SDA.
REQ-014 Data bits SHALL be sampled MSB first on each synchronized SCL rising edge.
REQ-015 SDA SHALL change only on the cycle after a synchronized SCL falling edge is detected.
REQ-016 The states SHALL be IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-017 ADDR SHALL shift 8 bits; on a match with I2C_ADDR the block SHALL go to ADDR_ACK and drive SDA low for exactly one SCL period, otherwise it SHALL go to IDLE with SDA released.
REQ-018 If the R/W bit is 1, the block SHALL latch temp_in into a shadow register in the same cycle the address is matched, so reads of pointers 00/01 return a coherent pair.
REQ-019 Write path: the first byte after the address SHALL load the 8-bit pointer; each later byte SHALL write the register at the pointer and then increment the pointer.
REQ-020 Every write byte SHALL be ACKed, including writes to read-only or unmapped pointers, which SHALL be ignored.
REQ-021 Read map: 00 = shadow[15:8], 01 = shadow[7:0], 02 = 8'h00 (status), 03 = cfg_reg, 0B = DEVICE_ID (see REQ-031), all others = 8'h00.
REQ-022 Read path: the byte at the pointer SHALL be loaded on entry to RD_BYTE (rd_strobe pulses) and shifted out, after which the pointer SHALL increment.
REQ-023 In RD_ACK, an initiator ACK (SDA low) SHALL lead to RD_BYTE with the next byte; a NACK SHALL lead to IDLE with SDA released until the next START.
REQ-024 The pointer SHALL wrap from 8'hFF to 8'h00.
REQ-025 The pointer and cfg_reg SHALL persist across transactions.
REQ-026 A repeated START SHALL keep the pointer, so the sequence write-pointer, Sr, read reads from the new pointer.

Reset
REQ-027 While rst is high, the state SHALL be IDLE and SDA SHALL be released (z).
REQ-028 While rst is high, the outputs SHALL be busy = 0, rd_strobe = 0 and cfg_reg = 8'h00.
REQ-029 While rst is high, the pointer SHALL be 8'h00, the shadow register 16'h0000 and the synchronizers 1.
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously), and the block SHALL ignore the bus until the next START.

Configuration
REQ-031 When macro ADT_RESP_ID_REG_EN is defined, pointer 8'h0B SHALL read DEVICE_ID; when it is undefined, pointer 8'h0B SHALL read 8'h00 like any unmapped register.

Verification
REQ-032 With temp_in=16'h0C80, the sequence START, 0x96, 0x00, Sr, 0x97, read 2 bytes (ACK then NACK), STOP SHALL return 0x0C, 0x80 with SDA low at the 3 target ACK bits and busy cleared after STOP.
REQ-033 The sequence START, 0x96, 0x03, 0xA5, STOP SHALL set cfg_reg=8'hA5; a following pointer-03 read SHALL return 0xA5.
REQ-034 START, 0x94 (address 0x4A) SHALL leave SDA released at the ACK bit and the block SHALL stay IDLE until STOP; cfg_reg SHALL be unchanged.
REQ-035 With pointer 0x00 set and temp_in changed from 16'h0C80 to 16'h1900 between the two bytes of one read, the bytes SHALL be 0x0C, 0x80.
REQ-036 Pointer 0x0B read SHALL return 0xCB with ADT_RESP_ID_REG_EN defined and 0x00 without it.
REQ-037 rst pulsed during the 4th data bit of a read SHALL release SDA within 1 cycle and clear cfg_reg, and the next full transaction SHALL succeed.
